// File: rtl/rwl_pkg.sv
// rwl_pkg: shared types and constants for the read-wordline driver.
//   rwl_state_e     - driver FSM state (IDLE, DRIVE)
//   RWL_INPUT_WIDTH - default number of activation rows per vector
//   RWL_ACT_BITS    - default bits per activation
//   idx_w()         - width of the bit-index bus for a given activation width
package rwl_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } rwl_state_e;

    localparam int RWL_INPUT_WIDTH = 144;
    localparam int RWL_ACT_BITS    = 8;

    // Never narrower than one bit, even for 1- or 2-bit activations.
    function automatic int idx_w(input int act_bits);
        return (act_bits > 2) ? $clog2(act_bits) : 1;
    endfunction

endpackage

// File: rtl/rwl_driver_if.sv
// rwl_driver_if: vector-in / bit-slice-out bundle of the read-wordline driver.
//   in_valid, in_ready, in_act      - activation vector handshake
//   rwlb, bit_valid, bit_ready,
//   bit_idx, bit_last               - bit-slice beat stream toward local_mac
// master = the driver itself, slave = its environment (source + accumulator).
interface rwl_driver_if import rwl_pkg::*; #(
    parameter int INPUT_WIDTH = RWL_INPUT_WIDTH,
    parameter int ACT_BITS    = RWL_ACT_BITS
) ();
    localparam int IDX_W = idx_w(ACT_BITS);

    logic                            in_valid;
    logic                            in_ready;
    logic [INPUT_WIDTH*ACT_BITS-1:0] in_act;
    logic [INPUT_WIDTH-1:0]          rwlb;
    logic                            bit_valid;
    logic                            bit_ready;
    logic [IDX_W-1:0]                bit_idx;
    logic                            bit_last;

    modport master (
        input  in_valid, in_act, bit_ready,
        output in_ready, rwlb, bit_valid, bit_idx, bit_last
    );

    modport slave (
        output in_valid, in_act, bit_ready,
        input  in_ready, rwlb, bit_valid, bit_idx, bit_last
    );
endinterface

// File: rtl/rwl_driver_slice_prio_enc.sv
// slice_prio_enc: highest-set-bit encoder over a bit-plane mask.
//   mask_i  - remaining bit-plane mask
//   idx_o   - index of the highest set bit (0 when mask is empty)
//   found_o - mask has at least one bit set
//   below_o - some bit below idx_o is also set (i.e. idx_o is not the last beat)
module slice_prio_enc import rwl_pkg::*; #(
    parameter int ACT_BITS = RWL_ACT_BITS,
    parameter int IDX_W    = idx_w(ACT_BITS)
) (
    input  logic [ACT_BITS-1:0] mask_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                found_o,
    output logic                below_o
);
    logic [ACT_BITS-1:0] low_mask;

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        idx_o = '0;
        for (int k = 0; k < ACT_BITS; k++) begin
            if (mask_i[k]) begin
                idx_o = IDX_W'(k);
            end
        end
    end

    assign found_o  = |mask_i;
    assign low_mask = (ACT_BITS'(1) << idx_o) - ACT_BITS'(1);
    assign below_o  = |(mask_i & low_mask);

endmodule

// File: rtl/rwl_driver.sv
// rwl_driver: replays one activation vector as MSB-first bit-slices on rwlb.
//   clk, rst  - clock and asynchronous active-high reset
//   bus       - rwl_driver_if.master: vector input handshake and slice beat output
// SKIP_ZERO=1 drops all-zero bit-planes; an all-zero vector still yields one
// empty beat (idx 0, last) so the accumulator sees the vector complete.
module rwl_driver import rwl_pkg::*; #(
    parameter int INPUT_WIDTH = RWL_INPUT_WIDTH,
    parameter int ACT_BITS    = RWL_ACT_BITS,
    parameter bit SKIP_ZERO   = 1'b1
) (
    input logic          clk,
    input logic          rst,
    rwl_driver_if.master bus
);
    localparam int IDX_W = idx_w(ACT_BITS);

    typedef logic [INPUT_WIDTH-1:0][ACT_BITS-1:0] vec_t;

    rwl_state_e             state_q, state_d;
    vec_t                   vbuf_q, vbuf_d;
    logic [ACT_BITS-1:0]    mask_q, mask_d;
    logic [INPUT_WIDTH-1:0] rwlb_q, rwlb_d;
    logic                   bit_valid_q, bit_valid_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   bit_last_q, bit_last_d;

    vec_t                   in_vec;
    vec_t                   src_vec;
    logic [ACT_BITS-1:0]    nz_mask;
    logic [ACT_BITS-1:0]    enc_mask;
    logic [IDX_W-1:0]       enc_idx;
    logic                   enc_found;
    logic                   enc_below;
    logic [INPUT_WIDTH-1:0] slice;
    logic                   hs;
    logic                   in_ready;
    logic                   load;
    logic                   advance;

    assign in_vec   = bus.in_act;
    assign hs       = bit_valid_q && bus.bit_ready;
    // Only combinational input-to-output path: bit_ready -> in_ready.
    assign in_ready = (state_q == IDLE) || (hs && bit_last_q);
    assign load     = in_ready && bus.in_valid;
    assign advance  = hs && !bit_last_q;

    for (genvar b = 0; b < ACT_BITS; b++) begin : g_nz
        logic [INPUT_WIDTH-1:0] col;
        for (genvar r = 0; r < INPUT_WIDTH; r++) begin : g_col
            assign col[r] = in_vec[r][b];
        end
        assign nz_mask[b] = SKIP_ZERO ? |col : 1'b1;
    end

    // On a load the first beat comes straight from the incoming vector so it
    // is visible the cycle after acceptance; otherwise from the held buffer.
    assign enc_mask = load ? nz_mask : mask_q;
    assign src_vec  = load ? in_vec  : vbuf_q;

    slice_prio_enc #(
        .ACT_BITS (ACT_BITS),
        .IDX_W    (IDX_W)
    ) u_enc (
        .mask_i  (enc_mask),
        .idx_o   (enc_idx),
        .found_o (enc_found),
        .below_o (enc_below)
    );

    for (genvar r = 0; r < INPUT_WIDTH; r++) begin : g_slice
        assign slice[r] = src_vec[r][enc_idx];
    end

    always_comb begin
        state_d     = state_q;
        vbuf_d      = vbuf_q;
        mask_d      = mask_q;
        rwlb_d      = rwlb_q;
        bit_valid_d = bit_valid_q;
        bit_idx_d   = bit_idx_q;
        bit_last_d  = bit_last_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (hs && bit_last_q && !load) begin
                    state_d     = IDLE;
                    bit_valid_d = 1'b0;
                    rwlb_d      = '0;
                    bit_idx_d   = '0;
                    bit_last_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            vbuf_d = in_vec;
        end

        if (load || advance) begin
            rwlb_d      = enc_found ? slice : '0;
            bit_idx_d   = enc_idx;
            bit_last_d  = !enc_below;
            bit_valid_d = 1'b1;
            mask_d      = enc_mask & ~(ACT_BITS'(1) << enc_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vbuf_q      <= '0;
            mask_q      <= '0;
            rwlb_q      <= '0;
            bit_valid_q <= 1'b0;
            bit_idx_q   <= '0;
            bit_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vbuf_q      <= vbuf_d;
            mask_q      <= mask_d;
            rwlb_q      <= rwlb_d;
            bit_valid_q <= bit_valid_d;
            bit_idx_q   <= bit_idx_d;
            bit_last_q  <= bit_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.rwlb      = rwlb_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_idx   = bit_idx_q;
    assign bus.bit_last  = bit_last_q;

endmodule
